// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning the HI/LO registers.
// The result is computed on the launch cycle and parked in hi_nxt/lo_nxt;
// it is committed to HI/LO once the fixed busy window has elapsed.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDop,
  input  logic        E_start,
  input  logic [31:0] E_rsValue,
  input  logic [31:0] E_rtValue,
  output logic        E_busy,
  output logic [31:0] E_MDout
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  // The launch cycle is itself the first busy cycle, so RUN covers N-1
  // cycles and the counter loads N-2. A latency of 1 still spends one RUN cycle.
  localparam logic [CW-1:0] MULT_LOAD = CW'((MULT_CYCLES > 1) ? MULT_CYCLES - 2 : 0);
  localparam logic [CW-1:0] DIV_LOAD  = CW'((DIV_CYCLES  > 1) ? DIV_CYCLES  - 2 : 0);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic [31:0]     r_hi_nxt;
  logic [31:0]     r_lo_nxt;
  logic            r_nowrite;

  logic            w_is_md;
  logic            w_is_mul;
  logic            w_launch;
  logic            w_done;
  logic            w_busy;

  logic [63:0]     w_smul;
  logic [63:0]     w_umul;
  logic            w_sdiv;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [31:0]     w_a_mag;
  logic [31:0]     w_b_mag;
  logic            w_b_nz;
  logic [31:0]     w_den;
  logic [31:0]     w_q_mag;
  logic [31:0]     w_r_mag;
  logic [31:0]     w_q;
  logic [31:0]     w_r;
  logic [31:0]     w_res_hi;
  logic [31:0]     w_res_lo;
  logic            w_res_nowrite;

  assign w_is_md  = (E_MDop == OP_MULT) || (E_MDop == OP_MULTU) ||
                    (E_MDop == OP_DIV)  || (E_MDop == OP_DIVU);
  assign w_is_mul = (E_MDop == OP_MULT) || (E_MDop == OP_MULTU);
  assign w_launch = E_start && w_is_md && (r_state == S_IDLE);
  assign w_done   = (r_state == S_RUN) && (r_count == '0);
  assign w_busy   = E_start || (r_state == S_RUN);

  assign E_busy   = w_busy;
  assign E_MDout  = (E_MDop == OP_MFHI) ? r_hi : r_lo;

  // 64-bit products, explicit extension so both operands are full width.
  assign w_smul = $signed({{32{E_rsValue[31]}}, E_rsValue}) *
                  $signed({{32{E_rtValue[31]}}, E_rtValue});
  assign w_umul = {32'd0, E_rsValue} * {32'd0, E_rtValue};

  // Signed divide runs on magnitudes, then restores signs: quotient truncates
  // toward zero, remainder follows the dividend. 0x80000000 / -1 falls out as
  // magnitude 0x80000000 re-negated to itself with remainder 0.
  assign w_sdiv  = (E_MDop == OP_DIV);
  assign w_a_neg = w_sdiv && E_rsValue[31];
  assign w_b_neg = w_sdiv && E_rtValue[31];
  assign w_a_mag = w_a_neg ? (~E_rsValue + 32'd1) : E_rsValue;
  assign w_b_mag = w_b_neg ? (~E_rtValue + 32'd1) : E_rtValue;
  assign w_b_nz  = |E_rtValue;
  assign w_den   = w_b_nz ? w_b_mag : 32'd1;
  assign w_q_mag = w_a_mag / w_den;
  assign w_r_mag = w_a_mag % w_den;
  assign w_q     = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r     = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  // Select the result for the op being launched.
  always_comb begin
    w_res_hi      = '0;
    w_res_lo      = '0;
    w_res_nowrite = 1'b0;
    if (w_is_mul) begin
      if (E_MDop == OP_MULT) begin
        w_res_hi = w_smul[63:32];
        w_res_lo = w_smul[31:0];
      end else begin
        w_res_hi = w_umul[63:32];
        w_res_lo = w_umul[31:0];
      end
    end else begin
      w_res_hi      = w_r;
      w_res_lo      = w_q;
      w_res_nowrite = !w_b_nz;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: launch from IDLE, return when the counter expires.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_launch) w_state_nxt = S_RUN;
      S_RUN:   if (w_done)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: pending result capture, countdown, HI/LO commit and mt writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_hi_nxt  <= '0;
      r_lo_nxt  <= '0;
      r_nowrite <= 1'b0;
    end else begin
      if (w_launch) begin
        r_hi_nxt  <= w_res_hi;
        r_lo_nxt  <= w_res_lo;
        r_nowrite <= w_res_nowrite;
        r_count   <= w_is_mul ? MULT_LOAD : DIV_LOAD;
      end else if (r_state == S_RUN) begin
        if (w_done) begin
          if (!r_nowrite) begin
            r_hi <= r_hi_nxt;
            r_lo <= r_lo_nxt;
          end
        end else begin
          r_count <= r_count - 1'b1;
        end
      end
      if (!w_busy && (E_MDop == OP_MTHI)) r_hi <= E_rsValue;
      if (!w_busy && (E_MDop == OP_MTLO)) r_lo <= E_rsValue;
    end
  end

endmodule
